// File: rtl/upsample_pkg.sv
// Shared types and helpers for the nearest-neighbour upsampler: FSM states,
// legal element widths, and the line-buffer sizing rule.
package upsample_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, LOAD, EMIT, DONE} state_t;

  localparam logic [7:0] EB_2  = 8'd2;
  localparam logic [7:0] EB_4  = 8'd4;
  localparam logic [7:0] EB_8  = 8'd8;
  localparam logic [7:0] EB_16 = 8'd16;
  localparam logic [7:0] EB_32 = 8'd32;

  function automatic logic eb_legal(input logic [7:0] eb);
    return (eb == EB_2) || (eb == EB_4) || (eb == EB_8) ||
           (eb == EB_16) || (eb == EB_32);
  endfunction

  function automatic logic [2:0] eb_log2(input logic [7:0] eb);
    case (eb)
      EB_2:    return 3'd1;
      EB_4:    return 3'd2;
      EB_8:    return 3'd3;
      EB_16:   return 3'd4;
      EB_32:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Words needed to hold the largest packed input row.
  function automatic int lbuf_depth(input int max_row_bytes, input int bus_w);
    return (max_row_bytes * 8 + bus_w - 1) / bus_w;
  endfunction

endpackage

// File: rtl/elem_packer.sv
// Packs a serial element stream LSB-first into BUS_W beats and owns the
// output register; a row-end flag flushes the partial beat zero-padded.
module elem_packer
  import upsample_pkg::*;
#(
  parameter int BUS_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             elem_valid,
  input  logic [31:0]      elem_data,
  input  logic [2:0]       elem_shift,
  input  logic             elem_last,
  output logic             elem_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PW = $clog2(BUS_W);

  logic [BUS_W-1:0] acc;
  logic [PW-1:0]    ptr;
  logic [PW:0]      ptr_nxt;
  logic [BUS_W-1:0] merged;
  logic             complete;
  logic             stall;

  assign ptr_nxt    = {1'b0, ptr} + ((PW+1)'(1) << elem_shift);
  assign merged     = acc | (BUS_W'(elem_data) << ptr);
  assign complete   = elem_last || ptr_nxt[PW];
  // Hold the walker only when a finished beat has nowhere to go.
  assign stall      = complete && out_valid && !out_ready;
  assign elem_ready = !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ptr       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (elem_valid && !stall) begin
        if (complete) begin
          out_data  <= merged;
          out_valid <= 1'b1;
          acc       <= '0;
          ptr       <= '0;
        end else begin
          acc <= merged;
          ptr <= ptr_nxt[PW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/upsample2d_nn_unit.sv
// Nearest-neighbour 2D upsampler: row line buffer, element-serial walker and
// job FSM. Define UPSAMPLE_PINGPONG_EN for two line buffers (overlapped load/emit).
module upsample2d_nn_unit
  import upsample_pkg::*;
#(
  parameter int BUS_W         = 128,
  parameter int MAX_ROW_BYTES = 2048,
  parameter int MAX_SCALE     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cfg_elem_bits,
  input  logic [7:0]       cfg_scale_h,
  input  logic [7:0]       cfg_scale_w,
  input  logic [15:0]      cfg_h_in,
  input  logic [15:0]      cfg_w_in,
  input  logic [15:0]      cfg_c,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [BUS_W-1:0] act_in_data,
  input  logic             act_in_valid,
  output logic             act_in_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LOG_BUS = $clog2(BUS_W);
  localparam int DEPTH   = lbuf_depth(MAX_ROW_BYTES, BUS_W);
  localparam int DW      = $clog2(DEPTH);
  localparam int PSW     = LOG_BUS + DW;
  localparam logic [39:0] MAX_ROW_BITS = 40'(MAX_ROW_BYTES * 8);
`ifdef UPSAMPLE_PINGPONG_EN
  localparam int   NBUF = 2;
  localparam logic PP   = 1'b1;
`else
  localparam int   NBUF = 1;
  localparam logic PP   = 1'b0;
`endif
  localparam int AW = $clog2(NBUF * DEPTH);

  state_t      state;
  logic [7:0]  eb, sh, sw;
  logic [15:0] h_in, w_in, ch, beats;
  logic [2:0]  shift;

  logic        ld_active, wr_sel, rd_sel;
  logic [15:0] ld_beat, ld_row;
  logic [1:0]  full;

  logic [15:0] px, cc, em_row;
  logic [7:0]  rep_w, rep_h;
  logic [19:0] pix_base;
  logic        walk_done;

  logic [BUS_W-1:0] lbuf [NBUF*DEPTH];

  logic [39:0] row_bits;
  logic        cfg_ok;
  logic        ld_fire, ld_last;
  logic [19:0] idx;
  logic [PSW-1:0] pos;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic [BUS_W-1:0] rd_word;
  logic [31:0] elem_mask, elem_data;
  logic        elem_valid, elem_ready, elem_fire, elem_last;
  logic        last_c, last_rw, last_px, row_end_fire;

  assign row_bits = 40'(w_in) * 40'(ch) * 40'(eb);
  assign cfg_ok = eb_legal(eb) &&
                  (sh != 8'd0) && (sh <= 8'(MAX_SCALE)) &&
                  (sw != 8'd0) && (sw <= 8'(MAX_SCALE)) &&
                  (h_in != 16'd0) && (w_in != 16'd0) && (ch != 16'd0) &&
                  (row_bits <= MAX_ROW_BITS);

  assign act_in_ready = ld_active && !full[wr_sel];
  assign ld_fire      = act_in_valid && act_in_ready;
  assign ld_last      = (ld_beat == beats - 16'd1);
  assign busy         = (state != IDLE);

  // Element address in the packed row: bit position = idx << log2(eb).
  assign idx = pix_base + {4'd0, cc};
  assign pos = PSW'(idx) << shift;
`ifdef UPSAMPLE_PINGPONG_EN
  assign rd_addr = {rd_sel, pos[LOG_BUS +: DW]};
  assign wr_addr = {wr_sel, ld_beat[DW-1:0]};
`else
  assign rd_addr = pos[LOG_BUS +: DW];
  assign wr_addr = ld_beat[DW-1:0];
`endif
  assign rd_word   = lbuf[rd_addr];
  assign elem_mask = 32'hFFFF_FFFF >> (8'd32 - eb);
  assign elem_data = 32'(rd_word >> pos[LOG_BUS-1:0]) & elem_mask;

  assign last_c       = (cc == ch - 16'd1);
  assign last_rw      = (rep_w == sw - 8'd1);
  assign last_px      = (px == w_in - 16'd1);
  assign elem_last    = last_c && last_rw && last_px;
  assign elem_valid   = (state == EMIT) && !walk_done;
  assign elem_fire    = elem_valid && elem_ready;
  assign row_end_fire = elem_fire && elem_last && (rep_h == sh - 8'd1);

  always_ff @(posedge clk) begin
    if (ld_fire)
      lbuf[wr_addr] <= act_in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      eb        <= '0;
      sh        <= '0;
      sw        <= '0;
      h_in      <= '0;
      w_in      <= '0;
      ch        <= '0;
      shift     <= '0;
      beats     <= '0;
      ld_active <= 1'b0;
      ld_beat   <= '0;
      ld_row    <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      full      <= '0;
      px        <= '0;
      cc        <= '0;
      em_row    <= '0;
      rep_w     <= '0;
      rep_h     <= '0;
      pix_base  <= '0;
      walk_done <= 1'b0;
    end else begin
      done <= 1'b0;

      if (ld_fire) begin
        if (ld_last) begin
          ld_beat      <= '0;
          full[wr_sel] <= 1'b1;
          wr_sel       <= wr_sel ^ PP;
          ld_row       <= ld_row + 16'd1;
          if (ld_row == h_in - 16'd1)
            ld_active <= 1'b0;
        end else begin
          ld_beat <= ld_beat + 16'd1;
        end
      end

      // Walk order: channel fastest, then horizontal repeat, then pixel.
      if (elem_fire) begin
        if (!last_c) begin
          cc <= cc + 16'd1;
        end else begin
          cc <= '0;
          if (!last_rw) begin
            rep_w <= rep_w + 8'd1;
          end else begin
            rep_w <= '0;
            if (!last_px) begin
              px       <= px + 16'd1;
              pix_base <= pix_base + 20'(ch);
            end else begin
              px       <= '0;
              pix_base <= '0;
              if (rep_h != sh - 8'd1) begin
                rep_h <= rep_h + 8'd1;
              end else begin
                rep_h        <= '0;
                full[rd_sel] <= 1'b0;
                rd_sel       <= rd_sel ^ PP;
                if (em_row == h_in - 16'd1)
                  walk_done <= 1'b1;
                else
                  em_row <= em_row + 16'd1;
              end
            end
          end
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            eb    <= cfg_elem_bits;
            sh    <= cfg_scale_h;
            sw    <= cfg_scale_w;
            h_in  <= cfg_h_in;
            w_in  <= cfg_w_in;
            ch    <= cfg_c;
            shift <= eb_log2(cfg_elem_bits);
            err   <= 1'b0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!cfg_ok) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            beats     <= 16'((row_bits + 40'(BUS_W - 1)) >> LOG_BUS);
            ld_active <= 1'b1;
            ld_beat   <= '0;
            ld_row    <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            full      <= '0;
            px        <= '0;
            cc        <= '0;
            em_row    <= '0;
            rep_w     <= '0;
            rep_h     <= '0;
            pix_base  <= '0;
            walk_done <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (full[rd_sel])
            state <= EMIT;
        end
        EMIT: begin
          if (row_end_fire && (em_row != h_in - 16'd1)) begin
            state <= LOAD;
          end else if (walk_done && !out_valid) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          walk_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  elem_packer #(.BUS_W(BUS_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .elem_valid (elem_valid),
    .elem_data  (elem_data),
    .elem_shift (shift),
    .elem_last  (elem_last),
    .elem_ready (elem_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

endmodule
